calc_sequencer: RTL and testbench

CALC_SEQUENCER -- requirements
Module: calc_sequencer

---
 rtl/calc_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_calc_sequencer.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: button-driven RPN calculator sequencer over a handshaked stack memory and an external ALU.
// Optional macro CALC_OVF_TRAP_EN: an ALU overflow re-pushes both operands instead of the result.
module calc_sequencer #(
   parameter int DATA_W = 32,
   parameter int SW_W   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [SW_W-1:0]   switches,
   input  logic [4:0]        btns,
   output logic              mem_req,
   output logic [1:0]        mem_cmd,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_empty,
   input  logic              mem_full,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [DATA_W-1:0] alu_y,
   input  logic              alu_ovf,
   output logic              busy,
   output logic              err,
   output logic [DATA_W-1:0] disp
);
   localparam logic [1:0] CMD_PUSH = 2'b01;
   localparam logic [1:0] CMD_POP  = 2'b10;

   typedef enum logic [2:0] {
      IDLE, PUSH_SW, POP_B, POP_A, RESTORE, EXEC, PUSH_R
`ifdef CALC_OVF_TRAP_EN
      , RESTORE_2
`endif
   } state_t;

   state_t            state, state_n;
   logic [4:0]        btns_q;
   logic [4:0]        rise;
   logic [SW_W-1:0]   sw_q;
   logic [DATA_W-1:0] a_q, b_q, r_q;
   logic [DATA_W-1:0] disp_n;
   logic [3:0]        op_n;
   logic              sw_ld, a_ld, b_ld, r_ld, op_ld, disp_ld, err_set, err_clr;

`ifdef CALC_OVF_TRAP_EN
`else
   logic unused_ovf;
   assign unused_ovf = alu_ovf;
`endif

   // btns_q resets to all-ones so a button held through reset release is not seen as a press
   assign rise = btns & ~btns_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n   = state;
      mem_req   = 1'b0;
      mem_cmd   = 2'b00;
      mem_wdata = '0;
      busy      = (state != IDLE);
      sw_ld     = 1'b0;
      a_ld      = 1'b0;
      b_ld      = 1'b0;
      r_ld      = 1'b0;
      op_ld     = 1'b0;
      op_n      = 4'b0000;
      disp_ld   = 1'b0;
      disp_n    = '0;
      err_set   = 1'b0;
      err_clr   = 1'b0;
      case (state)
         IDLE: begin
            if (rise[0]) begin
               err_clr = 1'b1;
               if (mem_full) begin
                  err_set = 1'b1;
               end else begin
                  sw_ld   = 1'b1;
                  state_n = PUSH_SW;
               end
            end else if (|rise[4:1]) begin
               err_clr = 1'b1;
               op_ld   = 1'b1;
               if (rise[1])      op_n = 4'b0001;
               else if (rise[2]) op_n = 4'b0010;
               else if (rise[3]) op_n = 4'b0100;
               else              op_n = 4'b1000;
               if (mem_empty) begin
                  err_set = 1'b1;
               end else begin
                  state_n = POP_B;
               end
            end
         end
         PUSH_SW: begin
            mem_req   = 1'b1;
            mem_cmd   = CMD_PUSH;
            mem_wdata = DATA_W'(sw_q);
            if (mem_ack) begin
               disp_ld = 1'b1;
               disp_n  = DATA_W'(sw_q);
               state_n = IDLE;
            end
         end
         // mem_empty during the ack cycle tells whether a second operand remains
         POP_B: begin
            mem_req = 1'b1;
            mem_cmd = CMD_POP;
            if (mem_ack) begin
               b_ld    = 1'b1;
               state_n = mem_empty ? RESTORE : POP_A;
            end
         end
         POP_A: begin
            mem_req = 1'b1;
            mem_cmd = CMD_POP;
            if (mem_ack) begin
               a_ld    = 1'b1;
               state_n = EXEC;
            end
         end
         EXEC: begin
            r_ld = 1'b1;
`ifdef CALC_OVF_TRAP_EN
            state_n = alu_ovf ? RESTORE_2 : PUSH_R;
`else
            state_n = PUSH_R;
`endif
         end
         PUSH_R: begin
            mem_req   = 1'b1;
            mem_cmd   = CMD_PUSH;
            mem_wdata = r_q;
            if (mem_ack) begin
               disp_ld = 1'b1;
               disp_n  = r_q;
               state_n = IDLE;
            end
         end
         RESTORE: begin
            mem_req   = 1'b1;
            mem_cmd   = CMD_PUSH;
            mem_wdata = b_q;
            if (mem_ack) begin
               err_set = 1'b1;
               state_n = IDLE;
            end
         end
`ifdef CALC_OVF_TRAP_EN
         // A goes back first so B ends on top again, as before the operation
         RESTORE_2: begin
            mem_req   = 1'b1;
            mem_cmd   = CMD_PUSH;
            mem_wdata = a_q;
            if (mem_ack) begin
               state_n = RESTORE;
            end
         end
`endif
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btns_q <= '1;
         sw_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         r_q    <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
         alu_op <= '0;
         err    <= 1'b0;
         disp   <= '0;
      end else begin
         btns_q <= btns;
         if (sw_ld) sw_q <= switches;
         if (b_ld) b_q <= mem_rdata;
         // ALU operands change only on entry to EXEC and hold afterwards
         if (a_ld) begin
            a_q   <= mem_rdata;
            alu_a <= mem_rdata;
            alu_b <= b_q;
         end
         if (r_ld) r_q <= alu_y;
         if (op_ld) alu_op <= op_n;
         if (err_set) err <= 1'b1;
         else if (err_clr) err <= 1'b0;
         if (disp_ld) disp <= disp_n;
      end
   end

endmodule

// File: tb/tb_calc_sequencer.sv
// Testbench for calc_sequencer: stack-memory and ALU models plus a queue-based calculator reference model.
module tb_calc_sequencer;
   localparam int DEPTH = 8;
`ifdef CALC_OVF_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clk, rst;
   logic [15:0] switches;
   logic [4:0]  btns;
   logic        mem_req, mem_ack, mem_empty, mem_full, alu_ovf, busy, err;
   logic [1:0]  mem_cmd;
   logic [31:0] mem_wdata, mem_rdata, alu_a, alu_b, alu_y, disp;
   logic [3:0]  alu_op;

   calc_sequencer #(.DATA_W(32), .SW_W(16)) dut (
      .clk(clk), .rst(rst), .switches(switches), .btns(btns),
      .mem_req(mem_req), .mem_cmd(mem_cmd), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata), .mem_empty(mem_empty), .mem_full(mem_full),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_y(alu_y), .alu_ovf(alu_ovf),
      .busy(busy), .err(err), .disp(disp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // stack memory model; flags during an accepted pop already reflect the pop
   logic [31:0] mem_arr [0:15];
   logic [33:0] mlog [$];
   int          sp = 0, wait_cnt = 0, req_cnt = 0, unstable = 0, ack_dly = 0;
   bit          force_full = 1'b0, pl_go = 1'b0, pend_q = 1'b0;
   logic [31:0] pl_a, pl_b, wd_q;
   logic [1:0]  cmd_q;

   always_comb begin
      mem_ack   = mem_req && (wait_cnt >= ack_dly);
      mem_rdata = (sp > 0) ? mem_arr[4'(sp - 1)] : 32'h0;
      if (mem_req && mem_ack && mem_cmd == 2'b10) mem_empty = (sp <= 1);
      else mem_empty = (sp == 0);
      mem_full = force_full || (sp >= DEPTH);
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         sp       <= 0;
         wait_cnt <= 0;
         pend_q   <= 1'b0;
      end else begin
         if (pl_go) begin
            mem_arr[0] <= pl_a;
            mem_arr[1] <= pl_b;
            sp         <= 2;
         end else if (mem_req && mem_ack) begin
            if (mem_cmd == 2'b01) begin
               mem_arr[4'(sp)] <= mem_wdata;
               sp <= sp + 1;
            end else if (mem_cmd == 2'b10 && sp > 0) begin
               sp <= sp - 1;
            end
            mlog.push_back({mem_cmd, (mem_cmd == 2'b01) ? mem_wdata : mem_rdata});
         end
         if (mem_req) req_cnt <= req_cnt + 1;
         wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
         if (pend_q && (!mem_req || mem_cmd != cmd_q || mem_wdata != wd_q)) unstable <= unstable + 1;
         pend_q <= mem_req && !mem_ack;
         cmd_q  <= mem_cmd;
         wd_q   <= mem_wdata;
      end
   end

   // ALU model: add, sub, and, xor with signed overflow flag
   always_comb begin
      alu_y   = 32'h0;
      alu_ovf = 1'b0;
      case (alu_op)
         4'b0001: begin
            alu_y   = alu_a + alu_b;
            alu_ovf = (alu_a[31] == alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         4'b0010: begin
            alu_y   = alu_a - alu_b;
            alu_ovf = (alu_a[31] != alu_b[31]) && (alu_y[31] != alu_a[31]);
         end
         4'b0100: alu_y = alu_a & alu_b;
         4'b1000: alu_y = alu_a ^ alu_b;
         default: ;
      endcase
   end

   int          total = 0, bad = 0;
   logic [31:0] ref_stk [$];
   logic [31:0] ref_disp;
   logic        ref_err;
   logic [3:0]  ref_op;
   logic [33:0] exp_log [$];

   function automatic void ref_alu(input int k, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] y, output bit ovf);
      longint s;
      ovf = 1'b0;
      if (k == 1 || k == 2) begin
         s   = (k == 1) ? longint'($signed(a)) + longint'($signed(b))
                        : longint'($signed(a)) - longint'($signed(b));
         ovf = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
         y   = s[31:0];
      end else if (k == 3) begin
         y = a & b;
      end else begin
         y = a ^ b;
      end
   endfunction

   // expected calculator behaviour and busy-cycle count for one press with ack delay d
   task automatic model_press(input logic [4:0] b, input logic [15:0] sw, input int d, output int lat);
      logic [31:0] av, bv, y;
      bit ovf;
      int k;
      lat = 0;
      if (b[0]) begin
         if (force_full || ref_stk.size() >= DEPTH) ref_err = 1'b1;
         else begin
            ref_stk.push_back({16'h0, sw});
            ref_disp = {16'h0, sw};
            ref_err  = 1'b0;
            lat      = 1 + d;
         end
      end else if (b[4:1] != 4'b0) begin
         k      = b[1] ? 1 : b[2] ? 2 : b[3] ? 3 : 4;
         ref_op = 4'b0001 << (k - 1);
         if (ref_stk.size() == 0) ref_err = 1'b1;
         else if (ref_stk.size() == 1) begin
            ref_err = 1'b1;
            lat     = 2 + 2 * d;
         end else begin
            bv = ref_stk.pop_back();
            av = ref_stk.pop_back();
            ref_alu(k, av, bv, y, ovf);
            if (ovf && TRAP) begin
               ref_stk.push_back(av);
               ref_stk.push_back(bv);
               ref_err = 1'b1;
               lat     = 5 + 4 * d;
            end else begin
               ref_stk.push_back(y);
               ref_disp = y;
               ref_err  = 1'b0;
               lat      = 4 + 3 * d;
            end
         end
      end
   endtask

   // press buttons b, return number of busy cycles (-1 if the DUT never goes idle)
   task automatic press(input logic [4:0] b, output int n);
      @(negedge clk);
      btns = b;
      n = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy) begin
            n = i;
            break;
         end
      end
      btns = 5'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; btns = 5'b0; force_full = 1'b0; ack_dly = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ref_stk.delete();
      ref_err = 1'b0; ref_disp = 32'h0; ref_op = 4'h0;
   endtask

   task automatic push_sw(input logic [15:0] v);
      int n;
      switches = v;
      press(5'b00001, n);
   endtask

   task automatic test_reset();
      int n, rc, base;
      switches = 16'h0005;
      @(negedge clk);
      btns = 5'b00001;
      rst  = 1'b1;
      repeat (3) @(negedge clk);
      total++; if ({mem_req, mem_cmd, busy, err} !== 5'b0) begin bad++; $display("FAIL rst_ctrl: got %b want 00000", {mem_req, mem_cmd, busy, err}); end
      total++; if ({mem_wdata, disp} !== 64'h0) begin bad++; $display("FAIL rst_data: got %h want 0", {mem_wdata, disp}); end
      total++; if ({alu_a, alu_b, alu_op} !== 68'h0) begin bad++; $display("FAIL rst_alu: got %h want 0", {alu_a, alu_b, alu_op}); end
      rc  = req_cnt;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      total++; if (req_cnt != rc) begin bad++; $display("FAIL rst_held_btn: got %0d requests want 0", req_cnt - rc); end
      btns = 5'b0;
      base = mlog.size();
      press(5'b00001, n);
      total++; if (mlog.size() - base != 1) begin bad++; $display("FAIL rst_repress_count: got %0d want 1", mlog.size() - base); end
      total++; if (mlog.size() > base && mlog[base] !== {2'b01, 32'h5}) begin bad++; $display("FAIL rst_repress_push: got %h want %h", mlog[base], {2'b01, 32'h5}); end
      total++; if (n != 1) begin bad++; $display("FAIL rst_enter_latency: got %0d want 1", n); end
      total++; if (disp !== 32'h5) begin bad++; $display("FAIL rst_disp: got %h want 5", disp); end
   endtask

   task automatic test_add();
      int n, base;
      do_reset();
      push_sw(16'd3);
      push_sw(16'd4);
      base = mlog.size();
      press(5'b00010, n);
      exp_log.delete();
      exp_log.push_back({2'b10, 32'd4}); exp_log.push_back({2'b10, 32'd3}); exp_log.push_back({2'b01, 32'd7});
      total++; if (mlog.size() - base != exp_log.size()) begin bad++; $display("FAIL add_count: got %0d want %0d", mlog.size() - base, exp_log.size()); end
      for (int i = 0; i < exp_log.size() && base + i < mlog.size(); i++) begin
         total++; if (mlog[base + i] !== exp_log[i]) begin bad++; $display("FAIL add_txn%0d: got %h want %h", i, mlog[base + i], exp_log[i]); end
      end
      total++; if (n != 4) begin bad++; $display("FAIL add_latency: got %0d want 4", n); end
      total++; if ({alu_a, alu_b, alu_op} !== {32'd3, 32'd4, 4'b0001}) begin bad++; $display("FAIL add_alu: got %h want %h", {alu_a, alu_b, alu_op}, {32'd3, 32'd4, 4'b0001}); end
      total++; if ({disp, err, busy} !== {32'd7, 2'b00}) begin bad++; $display("FAIL add_status: got %h want %h", {disp, err, busy}, {32'd7, 2'b00}); end
   endtask

   task automatic test_restore();
      int n, base;
      do_reset();
      push_sw(16'd9);
      base = mlog.size();
      press(5'b00100, n);
      exp_log.delete();
      exp_log.push_back({2'b10, 32'd9}); exp_log.push_back({2'b01, 32'd9});
      total++; if (mlog.size() - base != 2) begin bad++; $display("FAIL restore_count: got %0d want 2", mlog.size() - base); end
      for (int i = 0; i < 2 && base + i < mlog.size(); i++) begin
         total++; if (mlog[base + i] !== exp_log[i]) begin bad++; $display("FAIL restore_txn%0d: got %h want %h", i, mlog[base + i], exp_log[i]); end
      end
      total++; if ({err, busy} !== 2'b10) begin bad++; $display("FAIL restore_flags: got %b want 10", {err, busy}); end
      total++; if (sp != 1 || mem_arr[0] !== 32'd9) begin bad++; $display("FAIL restore_mem: got sp=%0d top=%h want sp=1 top=9", sp, mem_arr[0]); end
      total++; if (n != 2) begin bad++; $display("FAIL restore_latency: got %0d want 2", n); end
      push_sw(16'd1);
      total++; if ({err, disp} !== {1'b0, 32'd1}) begin bad++; $display("FAIL restore_clear: got %h want %h", {err, disp}, {1'b0, 32'd1}); end
   endtask

   task automatic test_full_prio();
      int n, rc, base;
      do_reset();
      force_full = 1'b1;
      rc = req_cnt;
      push_sw(16'h0011);
      total++; if (req_cnt != rc) begin bad++; $display("FAIL full_noreq: got %0d requests want 0", req_cnt - rc); end
      total++; if (err !== 1'b1) begin bad++; $display("FAIL full_err: got %b want 1", err); end
      force_full = 1'b0;
      switches = 16'h00AB;
      base = mlog.size();
      press(5'b00101, n);
      total++; if (mlog.size() - base != 1) begin bad++; $display("FAIL prio_count: got %0d want 1", mlog.size() - base); end
      total++; if (mlog.size() > base && mlog[base] !== {2'b01, 32'hAB}) begin bad++; $display("FAIL prio_push: got %h want %h", mlog[base], {2'b01, 32'hAB}); end
      total++; if ({err, disp} !== {1'b0, 32'hAB}) begin bad++; $display("FAIL prio_status: got %h want %h", {err, disp}, {1'b0, 32'hAB}); end
      do_reset();
      rc = req_cnt;
      press(5'b01000, n);
      total++; if (req_cnt != rc || err !== 1'b1) begin bad++; $display("FAIL empty_op: got req=%0d err=%b want req=0 err=1", req_cnt - rc, err); end
      total++; if (alu_op !== 4'b0100) begin bad++; $display("FAIL empty_op_latch: got %b want 0100", alu_op); end
   endtask

   task automatic test_delay();
      int n, u, base;
      do_reset();
      push_sw(16'd20);
      ack_dly = 3;
      u = unstable;
      push_sw(16'd5);
      base = mlog.size();
      press(5'b00010, n);
      total++; if (n != 13) begin bad++; $display("FAIL delay_latency: got %0d want 13", n); end
      total++; if (unstable != u) begin bad++; $display("FAIL delay_stable: got %0d unstable cycles want 0", unstable - u); end
      total++; if (mlog.size() - base != 3 || mlog[mlog.size() - 1] !== {2'b01, 32'd25}) begin bad++; $display("FAIL delay_result: got %h want %h", mlog[mlog.size() - 1], {2'b01, 32'd25}); end
      total++; if (disp !== 32'd25) begin bad++; $display("FAIL delay_disp: got %h want 25", disp); end
      ack_dly = 0;
   endtask

   task automatic test_ovf();
      int n, base, exp_n;
      logic [31:0] exp_disp;
      do_reset();
      push_sw(16'h0042);
      @(negedge clk);
      pl_a = 32'h7FFF_FFFF; pl_b = 32'h1; pl_go = 1'b1;
      @(negedge clk);
      pl_go = 1'b0;
      base = mlog.size();
      press(5'b00010, n);
      exp_log.delete();
      exp_log.push_back({2'b10, 32'h1}); exp_log.push_back({2'b10, 32'h7FFF_FFFF});
`ifdef CALC_OVF_TRAP_EN
      exp_log.push_back({2'b01, 32'h7FFF_FFFF}); exp_log.push_back({2'b01, 32'h1});
      exp_disp = 32'h42; exp_n = 5;
      total++; if (err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %b want 1", err); end
`else
      exp_log.push_back({2'b01, 32'h8000_0000});
      exp_disp = 32'h8000_0000; exp_n = 4;
      total++; if (err !== 1'b0) begin bad++; $display("FAIL ovf_err: got %b want 0", err); end
`endif
      total++; if (mlog.size() - base != exp_log.size()) begin bad++; $display("FAIL ovf_count: got %0d want %0d", mlog.size() - base, exp_log.size()); end
      for (int i = 0; i < exp_log.size() && base + i < mlog.size(); i++) begin
         total++; if (mlog[base + i] !== exp_log[i]) begin bad++; $display("FAIL ovf_txn%0d: got %h want %h", i, mlog[base + i], exp_log[i]); end
      end
      total++; if (disp !== exp_disp) begin bad++; $display("FAIL ovf_disp: got %h want %h", disp, exp_disp); end
      total++; if (n != exp_n) begin bad++; $display("FAIL ovf_latency: got %0d want %0d", n, exp_n); end
   endtask

   task automatic test_random();
      int n, lat, d, r;
      logic [4:0]  b;
      logic [15:0] sw;
      do_reset();
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         if (r < 4) b = 5'b00001;
         else if (r < 8) b = 5'b00010 << $urandom_range(0, 3);
         else b = 5'($urandom_range(1, 31));
         sw = 16'($urandom_range(0, 65535));
         d  = $urandom_range(0, 2);
         ack_dly    = d;
         switches   = sw;
         force_full = ($urandom_range(0, 9) == 0);
         model_press(b, sw, d, lat);
         press(b, n);
         total++; if (n != lat) begin bad++; $display("FAIL rnd%0d_latency: btns=%b got %0d want %0d", i, b, n, lat); end
         total++; if ({err, disp} !== {ref_err, ref_disp}) begin bad++; $display("FAIL rnd%0d_status: btns=%b got %h want %h", i, b, {err, disp}, {ref_err, ref_disp}); end
         total++; if (alu_op !== ref_op) begin bad++; $display("FAIL rnd%0d_op: got %b want %b", i, alu_op, ref_op); end
         total++; if (sp != ref_stk.size()) begin bad++; $display("FAIL rnd%0d_depth: got %0d want %0d", i, sp, ref_stk.size()); end
         for (int j = 0; j < ref_stk.size() && j < sp; j++) begin
            total++; if (mem_arr[4'(j)] !== ref_stk[j]) begin bad++; $display("FAIL rnd%0d_mem%0d: got %h want %h", i, j, mem_arr[4'(j)], ref_stk[j]); end
         end
      end
      force_full = 1'b0;
   endtask

   initial begin
      rst = 1'b0; btns = 5'b0; switches = 16'h0; pl_a = 32'h0; pl_b = 32'h0;
      test_reset();
      test_add();
      test_restore();
      test_full_prio();
      test_delay();
      test_ovf();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached before summary, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
